// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared constants and helpers for the input synchronizer/filter
package sync_pkg;

  localparam int MIN_STAGES = 2;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic bit params_legal(input int num_stages, input int filter_len);
    return (num_stages >= MIN_STAGES) && (filter_len >= 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - single-channel multi-flop synchronizer chain
module sync_chain
  import sync_pkg::*;
#(
  parameter int   NUM_STAGES = 2,
  parameter logic RST_VAL    = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  // Bit 0 is the only flop allowed to go metastable; later bits only see its resolved value.
  logic [NUM_STAGES-1:0] r_stage;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stage <= {NUM_STAGES{RST_VAL}};
    end else begin
      r_stage <= {r_stage[NUM_STAGES-2:0], async_in};
    end
  end

  assign sync_out = r_stage[NUM_STAGES-1];

endmodule

// File: rtl/sync_filter_multi.sv
// rtl/sync_filter_multi.sv - multi-channel synchronizer with debounce filter and edge pulses
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                NUM_STAGES = 2,
  parameter int                FILTER_LEN = 3,
  parameter logic [NUM_CH-1:0] RESET_VAL  = {NUM_CH{1'b1}}
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  localparam int             CW      = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  if (!params_legal(NUM_STAGES, FILTER_LEN)) begin : g_bad_params
    $error("sync_filter_multi: NUM_STAGES must be >= %0d and FILTER_LEN >= 1", MIN_STAGES);
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("sync_filter_multi: NUM_CH must be >= 1");
  end

  logic [NUM_CH-1:0] w_sync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          r_filt;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_match;
    logic          w_commit;

    sync_chain #(
      .NUM_STAGES (NUM_STAGES),
      .RST_VAL    (RESET_VAL[i])
    ) u_chain (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (async_in[i]),
      .sync_out (w_sync[i])
    );

    assign w_match  = (w_sync[i] == r_filt);
    assign w_commit = !w_match && (r_cnt == CNT_MAX);

    // Pulses are registered alongside r_filt so they line up with the filtered edge.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_filt <= RESET_VAL[i];
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_commit && w_sync[i];
        r_fall <= w_commit && !w_sync[i];
        if (w_match || w_commit) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_commit) begin
          r_filt <= w_sync[i];
        end
      end
    end

    assign filt_out[i]   = r_filt;
    assign rise_pulse[i] = r_rise;
    assign fall_pulse[i] = r_fall;
  end

  assign sync_out = w_sync;

endmodule

// File: tb/tb_sync_filter_multi.sv
// tb/tb_sync_filter_multi.sv - directed self-checking bench for sync_filter_multi
module tb_sync_filter_multi;

  logic       clk;
  logic       n_rst;
  logic [3:0] async_in;
  logic [3:0] sync_out;
  logic [3:0] filt_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;

  int n_cmp;
  int n_err;

  sync_filter_multi #(
    .NUM_CH     (4),
    .NUM_STAGES (2),
    .FILTER_LEN (3),
    .RESET_VAL  (4'b1111)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .async_in   (async_in),
    .sync_out   (sync_out),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] f,
                         input logic [3:0] r, input logic [3:0] fl);
    chk({tag, ".sync"}, {28'd0, sync_out}, {28'd0, s});
    chk({tag, ".filt"}, {28'd0, filt_out}, {28'd0, f});
    chk({tag, ".rise"}, {28'd0, rise_pulse}, {28'd0, r});
    chk({tag, ".fall"}, {28'd0, fall_pulse}, {28'd0, fl});
  endtask

  logic [3:0] exp_rise [1:9];
  logic [3:0] exp_fall [1:9];
  int         n_fall;
  bit         dipped;
  bit         saw_x;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    n_rst    = 1'b1;
    async_in = 4'b0000;

    // 1. power-on reset mid-cycle, before any clock edge
    #2 n_rst = 1'b0;
    #1 chk_all("por_now", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    repeat (3) cyc();
    chk_all("por_hold", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk) n_rst = 1'b1;
    cyc();
    chk_all("por_e1", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    cyc();
    chk_all("por_e2", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    repeat (2) cyc();
    chk_all("por_e4", 4'b0000, 4'b1111, 4'b0000, 4'b0000);
    cyc();
    chk_all("por_e5", 4'b0000, 4'b0000, 4'b0000, 4'b1111);
    cyc();
    chk_all("por_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (3) cyc();

    // 2. ch0 0->1
    @(negedge clk) async_in = 4'b0001;
    cyc();
    chk_all("rise_e1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc();
    chk_all("rise_e2", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) cyc();
    chk_all("rise_e4", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    cyc();
    chk_all("rise_e5", 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    cyc();
    chk_all("rise_e6", 4'b0001, 4'b0001, 4'b0000, 4'b0000);

    // 3. ch1 glitch rejection, then a real 3-cycle low
    @(negedge clk) async_in = 4'b0011;
    repeat (8) cyc();
    chk("glitch_pre.filt", {28'd0, filt_out}, 32'h3);
    @(negedge clk) async_in = 4'b0001;
    dipped = 1'b0;
    n_fall = 0;
    for (int e = 0; e < 10; e++) begin
      cyc();
      if (e == 1) async_in = 4'b0011;  // applied before next negedge: low for 2 edges
      if (!filt_out[1]) dipped = 1'b1;
      if (fall_pulse[1]) n_fall++;
    end
    chk("glitch2.filt_dip", {31'd0, dipped}, 32'd0);
    chk("glitch2.n_fall", n_fall, 0);
    @(negedge clk) async_in = 4'b0001;
    n_fall = 0;
    for (int e = 0; e < 10; e++) begin
      cyc();
      if (e == 2) async_in = 4'b0011;
      if (fall_pulse[1]) n_fall++;
    end
    chk("glitch3.n_fall", n_fall, 1);
    // ch1 returned high afterwards, so the filter follows it back up
    @(negedge clk) async_in = 4'b0001;
    repeat (8) cyc();
    chk("glitch3.filt", {28'd0, filt_out}, 32'h1);

    // 4. setup and hold window changes on ch2/ch3
    saw_x = 1'b0;
    @(negedge clk);
    #4 async_in = 4'b0101;
    @(posedge clk);
    #1 async_in = 4'b1101;
    if ($isunknown({sync_out, filt_out, rise_pulse, fall_pulse})) saw_x = 1'b1;
    for (int e = 0; e < 5; e++) begin
      cyc();
      if ($isunknown({sync_out, filt_out, rise_pulse, fall_pulse})) saw_x = 1'b1;
    end
    chk("viol.no_x", {31'd0, saw_x}, 32'd0);
    chk("viol.filt", {28'd0, filt_out}, 32'hD);

    // 5. reset while ch0 counter sits at 2
    @(negedge clk) async_in = 4'b1111;
    repeat (8) cyc();
    @(negedge clk) async_in = 4'b1110;
    repeat (4) cyc();
    chk_all("midrst_pre", 4'b1110, 4'b1111, 4'b0000, 4'b0000);
    #2 n_rst = 1'b0;
    #1 chk_all("midrst_now", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk) n_rst = 1'b1;
    repeat (4) cyc();
    chk_all("midrst_e4", 4'b1110, 4'b1111, 4'b0000, 4'b0000);
    cyc();
    chk_all("midrst_e5", 4'b1110, 4'b1110, 4'b0000, 4'b0001);
    repeat (3) cyc();

    // 6. staggered toggles, one channel per cycle
    for (int e = 1; e <= 9; e++) begin
      exp_rise[e] = 4'b0000;
      exp_fall[e] = 4'b0000;
    end
    exp_rise[5] = 4'b0001;
    exp_fall[6] = 4'b0010;
    exp_fall[7] = 4'b0100;
    exp_fall[8] = 4'b1000;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e <= 4) async_in[e-1] = ~async_in[e-1];
      cyc();
      chk($sformatf("stagger_e%0d.rise", e), {28'd0, rise_pulse}, {28'd0, exp_rise[e]});
      chk($sformatf("stagger_e%0d.fall", e), {28'd0, fall_pulse}, {28'd0, exp_fall[e]});
    end
    chk("stagger.filt", {28'd0, filt_out}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_filter_multi.md
# sync_filter_multi

Parametrised multi-channel input synchronizer with per-channel debounce filter and edge-pulse generation. It is the successor to the single-bit two-flop high-reset synchronizer. It sits at the chip boundary between asynchronous pins (buttons, external strobes, status lines) and the core clock domain. It replaces per-pin hand-instantiated synchronizers with one block that also cleans glitches and reports transitions.

## Interface
- NUM_CH, 4: number of independent channels; ≥1.
- NUM_STAGES, 2: synchronizer flops per channel; ≥2.
- FILTER_LEN, 3: consecutive stable cycles required before the filtered output changes; ≥1.
- RESET_VAL, {NUM_CH{1'b1}}: per-channel reset/inactive value, NUM_CH bits.

Ports:
- clk  in  1  core clock; one clock domain, all state on rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- async_in  in  NUM_CH  asynchronous inputs; no timing relation to clk.
- sync_out  out  NUM_CH  raw synchronized value (last chain stage).
- filt_out  out  NUM_CH  debounced value.
- rise_pulse  out  NUM_CH  one-cycle pulse on filt_out 0→1.
- fall_pulse  out  NUM_CH  one-cycle pulse on filt_out 1→0.

## Operation
- Channels are fully independent; there is no cross-channel interaction.
- Chain: NUM_STAGES flops in series per channel. Stage 0 samples async_in[i]. sync_out[i] is the final stage. Only stage 0 may go metastable.
- Filter: per channel, a counter of width $clog2(FILTER_LEN+1) and a filt_out register.
  - Match (sync_out == filt_out): counter ← 0.
  - Mismatch with counter < FILTER_LEN-1: counter ← counter+1.
  - Mismatch with counter == FILTER_LEN-1: filt_out ← sync_out, counter ← 0.
  - Any single-cycle reversion to match clears the counter, so glitches shorter than FILTER_LEN cycles never reach filt_out.
  - FILTER_LEN=1: filt_out is sync_out delayed one cycle.
- Edge pulses are registered and assert on the same edge filt_out changes.
  - rise_pulse[i] = 1 for exactly one cycle when filt_out[i] goes 0→1.
  - fall_pulse[i] = 1 for exactly one cycle when filt_out[i] goes 1→0.
  - rise_pulse[i] and fall_pulse[i] are never both 1.
- Reset (n_rst=0, takes effect immediately, mid-operation included):
  - all chain stages and filt_out ← RESET_VAL;
  - counters ← 0;
  - rise_pulse/fall_pulse ← 0.
- Reset release never generates a pulse, even if async_in ≠ RESET_VAL. The transition then propagates normally through chain and filter.

## Timing
- async_in change meeting setup before edge k:
  - sync_out updates at edge k+NUM_STAGES-1, visible after clk→Q;
  - filt_out and the pulse update at edge k+NUM_STAGES-1+FILTER_LEN.
- Default parameters: sync_out after 2 edges, filt_out and pulse after 5 edges.
- Setup or hold violation at stage 0: resolved value is either old or new. Latency is the nominal value or one cycle more. Outputs are always a clean 0/1.
- Input toggling faster than every FILTER_LEN cycles: filt_out holds and no pulses are produced.
- Pulse width is exactly one clk cycle. Back-to-back transitions are spaced at least FILTER_LEN cycles apart.

## Structure
- Shared package sync_pkg:
  - constant MIN_STAGES = 2;
  - function cnt_width(len) returning $clog2(len+1);
  - parameter legality checks (NUM_STAGES ≥ MIN_STAGES, FILTER_LEN ≥ 1) via elaboration-time assertions.
- Sub-module sync_chain: one channel, parameters NUM_STAGES and RST_VAL, ports clk, n_rst, async_in, sync_out. The top generates NUM_CH instances.
- Filter and edge logic live in a generate loop in the top. No separate module is needed.

## Test plan
All scenarios use NUM_CH=4, NUM_STAGES=2, FILTER_LEN=3, RESET_VAL=4'b1111, with inputs driven on the negedge.
1. Power-on reset: assert n_rst mid-cycle with async_in=4'b0000 → sync_out=filt_out=4'b1111, pulses 0, before any edge and throughout reset. On release, no pulse. fall_pulse=4'b1111 appears exactly 5 edges later.
2. Normal transition: ch0 0→1 after a settled 0 → sync_out[0] high after 2 edges, filt_out[0] and rise_pulse[0] after 5 edges. rise_pulse[0] is high exactly 1 cycle; other channels unchanged.
3. Glitch rejection: ch1 pulse low for 2 cycles from 1 → filt_out[1] stays 1, no fall_pulse. A 3-cycle low → filt_out[1]=0 and a single fall_pulse[1].
4. Timing violations: change ch2 inside the setup window (FF_SETUP/2 before the edge), and ch3 inside the hold window → sync_out and filt_out are never X. filt_out reaches the new value within 6 edges.
5. Reset mid-filter: counter at 2 on ch0 mismatch, assert n_rst → filt_out=4'b1111 and pulses=0 immediately, counter restarts from 0 after release.
6. Independence: toggle all 4 channels with staggered 1-cycle offsets → each rise_pulse/fall_pulse fires on its own channel's nominal edge.
